// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int JADDR_W      = 28;

  typedef enum logic [1:0] {
    RD_NONE,
    RD_BRANCH,
    RD_JUMP
  } redirect_e;

  // Queue entry at the default width: fetched PC and its instruction word.
  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] ir;
  } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; head is presented combinationally on dout.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = $bits(fq_entry_t),
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wp, rp;

  // Entry storage; a flushed push is dropped so stale data never lands.
  always_ff @(posedge clk) begin
    if (push && !flush)
      mem[wp] <= din;
  end

  // Pointers and occupancy; DEPTH is a power of 2 so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop)  rp <= rp + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign dout = mem[rp];

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch: loadable imem, PC/redirect logic, decoupling fetch queue.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int               XLEN       = XLEN_DEFAULT,
  parameter int               IMEM_DEPTH = 128,
  parameter int               QDEPTH     = 4,
  parameter logic [XLEN-1:0]  RESET_PC   = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [XLEN-1:0]               imem_wdata,
  input  logic                          br_take,
  input  logic [XLEN-1:0]               br_base,
  input  logic [XLEN-1:0]               br_offset,
  input  logic                          jump,
  input  logic [JADDR_W-1:0]            jump_addr,
  input  logic [XLEN-1:0]               jump_pc,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [XLEN-1:0]               out_ir,
  output logic [XLEN-1:0]               out_pc,
  output logic                          flush_br,
  output logic                          flush_j,
  output logic [$clog2(QDEPTH):0]       q_count
);

  localparam int AW = $clog2(IMEM_DEPTH);

  // Same layout as fq_entry_t, sized by this instance's XLEN.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ir;
  } entry_t;

  logic [XLEN-1:0] imem [IMEM_DEPTH];
  logic [XLEN-1:0] fpc, rd_pc, rd_ir, target;
  logic            rd_vld, issue, push, pop;
  redirect_e       cause;
  entry_t          head;

  // Only the jump target's upper bits come from jump_pc.
  logic unused_jpc_lo;
  assign unused_jpc_lo = ^jump_pc[JADDR_W-1:0];

  // Redirect mux: branch beats jump beats sequential.
  always_comb begin
    cause  = RD_NONE;
    target = '0;
    if (br_take) begin
      cause  = RD_BRANCH;
      target = br_base + br_offset;
    end else if (jump) begin
      cause  = RD_JUMP;
      target = {jump_pc[XLEN-1:JADDR_W], jump_addr};
    end
  end

  // Counting the in-flight read guarantees its push finds room.
  assign issue = (cause == RD_NONE) &&
                 ((int'(q_count) + int'(rd_vld)) < QDEPTH);
  assign push  = rd_vld && (cause == RD_NONE);
  assign pop   = out_valid && out_ready;

  // imem load port; reset blocks writes but leaves contents intact.
  always_ff @(posedge clk) begin
    if (rst && imem_we)
      imem[imem_waddr] <= imem_wdata;
  end

  // Synchronous read; upper PC bits are ignored so the index wraps.
  always_ff @(posedge clk) begin
    rd_ir <= imem[fpc[AW+1:2]];
  end

  // PC, in-flight tracking and registered redirect pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fpc      <= RESET_PC;
      rd_vld   <= 1'b0;
      rd_pc    <= '0;
      flush_br <= 1'b0;
      flush_j  <= 1'b0;
    end else begin
      flush_br <= (cause == RD_BRANCH);
      flush_j  <= (cause == RD_JUMP);
      rd_vld   <= issue;
      if (issue) rd_pc <= fpc;
      if (cause != RD_NONE) fpc <= target;
      else if (issue)       fpc <= fpc + XLEN'(4);
    end
  end

  fetch_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({rd_pc, rd_ir}),
    .pop   (pop),
    .flush (cause != RD_NONE),
    .dout  (head),
    .count (q_count)
  );

  assign out_valid = (q_count != '0);
  assign out_pc    = out_valid ? head.pc : '0;
  assign out_ir    = out_valid ? head.ir : '0;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed scenarios plus random traffic vs a queue model.
module tb_instr_fetch_queue;

  localparam int QD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_we = 1'b0;
  logic [6:0]  imem_waddr = '0;
  logic [31:0] imem_wdata = '0;
  logic        br_take = 1'b0;
  logic [31:0] br_base = '0, br_offset = '0;
  logic        jump = 1'b0;
  logic [27:0] jump_addr = '0;
  logic [31:0] jump_pc = '0;
  logic        out_valid, out_ready = 1'b1;
  logic [31:0] out_ir, out_pc;
  logic        flush_br, flush_j;
  logic [2:0]  q_count;

  always #5 clk = ~clk;

  instr_fetch_queue #(
    .XLEN(32), .IMEM_DEPTH(128), .QDEPTH(QD), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .br_take(br_take), .br_base(br_base), .br_offset(br_offset),
    .jump(jump), .jump_addr(jump_addr), .jump_pc(jump_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ir(out_ir), .out_pc(out_pc),
    .flush_br(flush_br), .flush_j(flush_j), .q_count(q_count)
  );

  // Reference model: a queue of fetched (pc, ir) pairs plus one outstanding read.
  typedef struct { logic [31:0] pc; logic [31:0] ir; } ent_t;
  ent_t        mq[$];
  ent_t        m_e;
  bit          m_inf, m_fbr, m_fj, m_redir, m_iss, m_pop;
  logic [31:0] m_ipc, m_iir, m_fpc, m_rdat;
  logic [31:0] mimem [128];

  int  n_chk = 0, n_pass = 0;
  bit  chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Advance the model on each rising edge using the inputs the DUT sees.
  always @(posedge clk) begin
    if (!rst) begin
      m_fpc = 32'h0;
      mq.delete();
      m_inf = 1'b0;
      m_fbr = 1'b0;
      m_fj  = 1'b0;
    end else begin
      m_redir = br_take || jump;
      m_pop   = (mq.size() != 0) && out_ready;
      m_iss   = !m_redir && ((mq.size() + int'(m_inf)) < QD);
      m_rdat  = mimem[m_fpc[8:2]];
      m_fbr   = br_take;
      m_fj    = jump && !br_take;
      if (m_redir) begin
        mq.delete();
        m_inf = 1'b0;
        m_fpc = br_take ? br_base + br_offset : {jump_pc[31:28], jump_addr};
      end else begin
        if (m_pop) void'(mq.pop_front());
        if (m_inf) begin
          m_e.pc = m_ipc;
          m_e.ir = m_iir;
          mq.push_back(m_e);
        end
        m_inf = m_iss;
        if (m_iss) begin
          m_ipc = m_fpc;
          m_iir = m_rdat;
          m_fpc = m_fpc + 32'd4;
        end
      end
      if (imem_we) mimem[imem_waddr] = imem_wdata;
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", out_valid, mq.size() != 0);
      check("q_count", q_count, mq.size());
      if (mq.size() != 0) begin
        check("out_pc", out_pc, mq[0].pc);
        check("out_ir", out_ir, mq[0].ir);
      end else begin
        check("out_pc_empty", out_pc, 0);
        check("out_ir_empty", out_ir, 0);
      end
      check("flush_br", flush_br, m_fbr);
      check("flush_j", flush_j, m_fj);
    end
  end

  initial begin
    tick; tick;
    // Load every word so the model knows the whole memory.
    rst = 1'b1;
    for (int i = 0; i < 128; i++) begin
      imem_we    = 1'b1;
      imem_waddr = 7'(i);
      imem_wdata = (i < 4) ? 32'h11 * (i + 1) : (32'h1000_0000 | 32'(i));
      tick;
    end
    imem_we = 1'b0;
    rst = 1'b0;
    tick; tick;
    chk_en = 1'b1;
    check("rst_valid", out_valid, 0);
    check("rst_count", q_count, 0);
    check("rst_pc", out_pc, 0);
    check("rst_ir", out_ir, 0);

    // Startup stream, one instruction per cycle.
    rst = 1'b1; out_ready = 1'b1;
    tick;
    check("t1_latency", out_valid, 0);
    tick;
    for (int k = 0; k < 4; k++) begin
      check("t1_valid", out_valid, 1);
      check("t1_pc", out_pc, 4 * k);
      check("t1_ir", out_ir, 32'h11 * (k + 1));
      tick;
    end

    // Backpressure: queue fills and holds its head.
    rst = 1'b0; tick; rst = 1'b1;
    out_ready = 1'b0;
    repeat (10) tick;
    check("t2_full", q_count, 4);
    check("t2_head", out_pc, 0);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("t2_valid", out_valid, 1);
      check("t2_pc", out_pc, 4 * k);
      tick;
    end

    // Branch redirect.
    br_take = 1'b1; br_base = 32'h10; br_offset = 32'h20;
    tick;
    br_take = 1'b0;
    check("t3_flush_br", flush_br, 1);
    check("t3_count", q_count, 0);
    tick;
    check("t3_pulse_end", flush_br, 0);
    check("t3_gap", out_valid, 0);
    tick;
    check("t3_valid", out_valid, 1);
    check("t3_pc", out_pc, 32'h30);
    check("t3_ir", out_ir, 32'h1000_000C);

    // Branch and jump together: branch wins.
    br_take = 1'b1; br_base = 32'h100; br_offset = 32'hFFFF_FFFC;
    jump = 1'b1; jump_pc = 32'hA000_0000; jump_addr = 28'h38;
    tick;
    br_take = 1'b0; jump = 1'b0;
    check("t4_flush_br", flush_br, 1);
    check("t4_flush_j", flush_j, 0);
    tick; tick;
    check("t4_pc", out_pc, 32'hFC);
    check("t4_ir", out_ir, 32'h1000_003F);

    // Jump redirect.
    jump = 1'b1; jump_pc = 32'hA000_0000; jump_addr = 28'h38;
    tick;
    jump = 1'b0;
    check("t5_flush_j", flush_j, 1);
    check("t5_flush_br", flush_br, 0);
    tick; tick;
    check("t5_pc", out_pc, 32'hA000_0038);
    check("t5_ir", out_ir, 32'h1000_000E);

    // Reset mid-stream with a read outstanding.
    tick; tick;
    rst = 1'b0;
    tick;
    rst = 1'b1;
    check("t6_valid", out_valid, 0);
    check("t6_count", q_count, 0);
    tick;
    check("t6_no_stale", out_valid, 0);
    tick;
    check("t6_pc", out_pc, 0);
    check("t6_ir", out_ir, 32'h11);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst        = ($urandom_range(0, 99) != 0);
      br_take    = ($urandom_range(0, 99) < 6);
      br_base    = $urandom;
      br_offset  = $urandom;
      jump       = ($urandom_range(0, 99) < 6);
      jump_pc    = $urandom;
      jump_addr  = 28'($urandom);
      out_ready  = ($urandom_range(0, 99) < 70);
      imem_we    = ($urandom_range(0, 99) < 10);
      imem_waddr = 7'($urandom);
      imem_wdata = $urandom;
      tick;
    end
    rst = 1'b1; br_take = 1'b0; jump = 1'b0; imem_we = 1'b0; out_ready = 1'b1;
    repeat (5) tick;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
